// File: rtl/vc_pop_arbiter.sv
// Pop sequencer for the VC0/VC1 input FIFO pair: weighted round-robin (or VC0 strict priority
// when STRICT_PRIO_EN is defined), back-pressure gating and a two-stage forward to the dest FIFOs.
module vc_pop_arbiter #(
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned WEIGHT0 = 3,
    parameter int unsigned WEIGHT1 = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              empty0,
    input  logic              empty1,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic              almost_full_d0,
    input  logic              almost_full_d1,
    input  logic              full_d0,
    input  logic              full_d1,
    output logic              pop0,
    output logic              pop1,
    output logic [DATA_W-1:0] out_data,
    output logic              push_d0,
    output logic              push_d1,
    output logic              active_vc,
    output logic              overflow_err
);

    localparam int unsigned DestBit = 8;
    localparam logic [3:0]  Weight0 = 4'(WEIGHT0);
    localparam logic [3:0]  Weight1 = 4'(WEIGHT1);

    typedef enum logic [1:0] {
        StIdle,
        StServe0,
        StServe1
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        burst_q, burst_d;
    logic              vld_q, vld_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              push_d0_q, push_d0_d;
    logic              push_d1_q, push_d1_d;
    logic              overflow_q, overflow_d;

    logic              req0, req1, ok;
    logic              grant0, grant1;
    logic [3:0]        burst_inc;
    logic [DATA_W-1:0] cap_word;

    assign req0 = !empty0;
    assign req1 = !empty1;
    // Destination is unknown until the word is popped, so either almost-full stalls the pop.
    assign ok   = !almost_full_d0 && !almost_full_d1;

    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        grant0    = 1'b0;
        grant1    = 1'b0;
        burst_inc = (burst_q == 4'd15) ? 4'd15 : burst_q + 4'd1;
`ifdef STRICT_PRIO_EN
        burst_d = '0;
        if (ok) begin
            if (req0) begin
                grant0  = 1'b1;
                state_d = StServe0;
            end else if (req1) begin
                grant1  = 1'b1;
                state_d = StServe1;
            end else begin
                state_d = StIdle;
            end
        end
`else
        unique case (state_q)
            StIdle: begin
                burst_d = '0;
                if (req0) begin
                    state_d = StServe0;
                end else if (req1) begin
                    state_d = StServe1;
                end
            end
            StServe0: begin
                if (ok) begin
                    if (req0) begin
                        grant0  = 1'b1;
                        burst_d = burst_inc;
                        // Switch decision uses the count including this pop: no bubble.
                        if (req1 && (burst_inc >= Weight0)) begin
                            state_d = StServe1;
                            burst_d = '0;
                        end
                    end else begin
                        burst_d = '0;
                        state_d = req1 ? StServe1 : StIdle;
                    end
                end
            end
            StServe1: begin
                if (ok) begin
                    if (req1) begin
                        grant1  = 1'b1;
                        burst_d = burst_inc;
                        if (req0 && (burst_inc >= Weight1)) begin
                            state_d = StServe0;
                            burst_d = '0;
                        end
                    end else begin
                        burst_d = '0;
                        state_d = req0 ? StServe0 : StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                burst_d = '0;
            end
        endcase
`endif
    end

    assign pop0      = grant0 && reset;
    assign pop1      = grant1 && reset;
    assign active_vc = (state_q == StServe1);

    // Stage 1 remembers which VC was popped; stage 2 captures its read data.
    always_comb begin
        vld_d      = pop0 || pop1;
        sel_d      = pop1;
        cap_word   = sel_q ? in1 : in0;
        out_data_d = vld_q ? cap_word : out_data_q;
        push_d0_d  = vld_q && !cap_word[DestBit];
        push_d1_d  = vld_q && cap_word[DestBit];
        overflow_d = overflow_q || (push_d0_q && full_d0) || (push_d1_q && full_d1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            burst_q    <= '0;
            vld_q      <= 1'b0;
            sel_q      <= 1'b0;
            out_data_q <= '0;
            push_d0_q  <= 1'b0;
            push_d1_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            vld_q      <= vld_d;
            sel_q      <= sel_d;
            out_data_q <= out_data_d;
            push_d0_q  <= push_d0_d;
            push_d1_q  <= push_d1_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_data     = out_data_q;
    assign push_d0      = push_d0_q;
    assign push_d1      = push_d1_q;
    assign overflow_err = overflow_q;

endmodule
